cfg_frame_loader: RTL and testbench
===================================

Name: cfg_frame_loader

Overview:
- Serial configuration loader that drives the parallel CONFIG_BIT/INIT ports of fabric primitives (const_unit, reg_unit, ALU, IO) from a bitstream arriving on an external IO pin.
- Hunts for a sync word, reads a frame-count header, then deserialises N frames of FRAME_WIDTH bits.
- Emits each completed frame as a one-cycle write strobe with its frame address.
- Sits between the external IO primitive (to_fabric side) and the per-tile config registers.

Parameters:
FRAME_WIDTH, 32, bits per configuration frame
NUM_FRAMES, 8, maximum frames per load; valid header counts are 1..NUM_FRAMES
ADDR_WIDTH, 3, width of frame_addr; must satisfy 2**ADDR_WIDTH >= NUM_FRAMES
SYNC_WORD, 32'hFAB0_5EED, 32-bit sync pattern, received MSB first

Ports:
clk  input  1  USER_CLK, rising-edge
rst  input  1  reset, synchronous, active-high
en  input  1  global enable; when low, all state holds and bit_valid is ignored
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is sampled on this clock edge (only when en=1)
frame_data  output  FRAME_WIDTH  last completed frame
frame_addr  output  ADDR_WIDTH  index of frame_data (0-based)
frame_we  output  1  one-cycle write strobe for frame_data/frame_addr
busy  output  1  high in HEADER, DATA and CRC states
done  output  1  sticky; load completed successfully
err  output  1  sticky; load aborted

Behaviour:
- Reset: state=HUNT, sync shifter=0, all counters=0, frame_data=0, frame_addr=0, frame_we=0, busy=0, done=0, err=0. A partially received frame is discarded and produces no frame_we.
- Accepted bit = clock edge with en=1 and bit_valid=1. All fields are received MSB first.
- HUNT:
  - Shift each accepted bit into a 32-bit shifter.
  - When the shifter equals SYNC_WORD after an accept, go to HEADER on that edge and clear done, err, and the shifter.
  - Detection slides bit by bit, so leading garbage is tolerated.
- HEADER:
  - Collect 8 bits into count N.
  - N==0 or N>NUM_FRAMES: set err, go to HUNT.
  - Otherwise go to DATA with frame index=0 and bit counter=0.
- DATA:
  - Shift bits into a FRAME_WIDTH register.
  - On the edge that accepts the last bit of a frame, load frame_data and set frame_addr=index and frame_we=1. The strobe is therefore visible the cycle after that accept (latency 1).
  - frame_we is cleared on the next edge unconditionally, regardless of en.
  - Increment index. After frame N-1: without CRC, set done on the same edge (done rises together with the final frame_we) and go to HUNT.
  - SYNC_WORD patterns inside DATA have no special meaning.
- Returning to HUNT always clears the shifter, so a new sync needs 32 fresh bits.
- A sync detected after done or err starts a new load. done and err are mutually exclusive.
- en low mid-field: counters and shift registers freeze; resuming continues seamlessly.
- Frame counters and bit counters use no wrap-around. The index never exceeds N-1.

Optional Feature:
- Macro: CFG_LOADER_CRC_EN.
- When defined:
  - After the last frame, go to CRC state and collect an 8-bit trailer.
  - CRC-8 uses poly 0x07, init 0x00, MSB-first, and is computed over all header and data bits.
  - Frame writes still happen as frames complete.
  - On the last trailer bit: match sets done; mismatch sets err. Either way, go to HUNT.
  - busy stays high during CRC.
- When undefined: no trailer, no CRC logic; done is set with the final frame_we.

Test Plan:
- Nominal load: sync 0xFAB05EED, N=2, frames 0xDEADBEEF and 0x12345678, continuous valid. Expected: frame_we pulses at addr0=0xDEADBEEF and addr1=0x12345678, each one cycle after the frame's last bit; done=1 with the second pulse; busy=0 afterwards.
- Stalls: same stream with random bit_valid gaps and en=0 for 5 cycles mid-frame 0. Expected: identical frame data and addresses, no extra frame_we pulses.
- Header bounds: N=0 gives err=1, no frame_we, back to HUNT; N=9 (NUM_FRAMES=8) gives err=1; N=8 with 8 frames gives 8 pulses at addr 0..7, then done.
- Reset mid-load: assert rst after 10 bits of frame 1. Expected: all outputs 0 the next cycle, no write for frame 1; a fresh full stream then loads correctly.
- Sync hunt: prefix garbage 0b101, then a partial sync 0xFAB0, then the full sync. Expected: lock only on the complete SYNC_WORD; a load using the sync word 0xFAB05EED as frame data is written normally.
- CFG_LOADER_CRC_EN: correct trailer gives done=1, err=0. Flipped trailer bit gives err=1, done=0, and both frames are still written.

Source files
------------

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: serial bitstream -> parallel config frame writes.
// Hunts SYNC_WORD, reads an 8-bit frame count N, then shifts in N frames
// of FRAME_WIDTH bits, MSB first. Each completed frame is presented one
// cycle after its last bit as frame_data/frame_addr with a frame_we strobe.
// Optional CRC-8 trailer check when CFG_LOADER_CRC_EN is defined.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : global enable, freezes all state when low
//   bit_in        : serial data bit
//   bit_valid     : bit_in is sampled on this edge
//   frame_data    : last completed frame
//   frame_addr    : 0-based index of frame_data
//   frame_we      : one-cycle write strobe
//   busy          : high in HEADER, DATA and CRC
//   done, err     : sticky load status, mutually exclusive
module cfg_frame_loader #(
  parameter int          FRAME_WIDTH = 32,
  parameter int          NUM_FRAMES  = 8,
  parameter int          ADDR_WIDTH  = 3,
  parameter logic [31:0] SYNC_WORD   = 32'hFAB0_5EED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [FRAME_WIDTH-1:0] frame_data,
  output logic [ADDR_WIDTH-1:0]  frame_addr,
  output logic                   frame_we,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CW = $clog2(FRAME_WIDTH > 8 ? FRAME_WIDTH : 8);
  localparam logic [CW-1:0] BONE = 1;
  localparam logic [ADDR_WIDTH-1:0] IONE = 1;

  typedef enum logic [1:0] {
    HUNT,
    HEADER,
    DATA,
    CRC
  } state_t;

  state_t state, state_nx;

  logic                   acc;
  logic [31:0]            sync_sr, sync_nx;
  logic [CW-1:0]          bcnt;
  // holds N during HEADER/DATA, reused for the trailer in CRC
  logic [7:0]             hdr, hdr_nx;
  logic [FRAME_WIDTH-1:0] dsr, dsr_nx;
  logic [ADDR_WIDTH-1:0]  idx;
  logic                   last8, last_bit, last_frame, hdr_bad;
  logic                   sync_hit, done_set, err_set;

`ifdef CFG_LOADER_CRC_EN
  logic [7:0] crc, crc_nx;
  logic       fb;

  always_comb begin
    fb     = crc[7] ^ bit_in;
    crc_nx = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  end
`endif

  assign acc  = en & bit_valid;
  assign busy = (state != HUNT);

  always_comb begin
    sync_nx    = {sync_sr[30:0], bit_in};
    hdr_nx     = {hdr[6:0], bit_in};
    dsr_nx     = {dsr[FRAME_WIDTH-2:0], bit_in};
    last8      = (bcnt == CW'(7));
    last_bit   = (bcnt == CW'(FRAME_WIDTH - 1));
    last_frame = (32'(idx) == 32'(hdr) - 32'd1);
    hdr_bad    = (hdr_nx == 8'd0) || (32'(hdr_nx) > NUM_FRAMES);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sync_hit = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (acc) begin
      unique case (state)
        HUNT: begin
          if (sync_nx == SYNC_WORD) begin
            sync_hit = 1'b1;
            state_nx = HEADER;
          end
        end
        HEADER: begin
          if (last8) begin
            if (hdr_bad) begin
              err_set  = 1'b1;
              state_nx = HUNT;
            end else begin
              state_nx = DATA;
            end
          end
        end
        DATA: begin
          if (last_bit && last_frame) begin
`ifdef CFG_LOADER_CRC_EN
            state_nx = CRC;
`else
            done_set = 1'b1;
            state_nx = HUNT;
`endif
          end
        end
        CRC: begin
`ifdef CFG_LOADER_CRC_EN
          if (last8) begin
            done_set = (hdr_nx == crc);
            err_set  = (hdr_nx != crc);
            state_nx = HUNT;
          end
`else
          state_nx = HUNT;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sr    <= '0;
      bcnt       <= '0;
      hdr        <= '0;
      dsr        <= '0;
      idx        <= '0;
      frame_data <= '0;
      frame_addr <= '0;
      frame_we   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
      crc        <= '0;
`endif
    end else begin
      frame_we <= 1'b0;
      if (acc) begin
        unique case (state)
          HUNT: begin
            // the shifter stays zero outside HUNT, so a relock
            // always needs 32 fresh bits
            sync_sr <= sync_hit ? '0 : sync_nx;
            bcnt    <= '0;
            hdr     <= '0;
            idx     <= '0;
          end
          HEADER: begin
            hdr  <= hdr_nx;
            bcnt <= last8 ? '0 : bcnt + BONE;
          end
          DATA: begin
            dsr <= dsr_nx;
            if (last_bit) begin
              bcnt       <= '0;
              frame_data <= dsr_nx;
              frame_addr <= idx;
              frame_we   <= 1'b1;
              if (!last_frame) idx <= idx + IONE;
            end else begin
              bcnt <= bcnt + BONE;
            end
          end
          CRC: begin
            hdr  <= hdr_nx;
            bcnt <= bcnt + BONE;
          end
        endcase
`ifdef CFG_LOADER_CRC_EN
        if (state == HUNT)
          crc <= '0;
        else if (state == HEADER || state == DATA)
          crc <= crc_nx;
`endif
      end
      if (sync_hit) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (done_set) done <= 1'b1;
      if (err_set)  err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader: directed, table-driven bench for cfg_frame_loader.
// Ports: none (drives clk/rst/en/bit_in/bit_valid, observes all outputs).
module tb_cfg_frame_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_5EED;

  logic        clk = 1'b0;
  logic        rst, en, bit_in, bit_valid;
  logic [31:0] frame_data;
  logic [2:0]  frame_addr;
  logic        frame_we, busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [31:0] fr [16];
  logic [7:0]  crc_m;
  logic [2:0]  wa [$];
  logic [31:0] wd [$];

  always #5 clk = ~clk;

  cfg_frame_loader dut (
    .clk(clk), .rst(rst), .en(en),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_data(frame_data), .frame_addr(frame_addr),
    .frame_we(frame_we), .busy(busy),
    .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (frame_we) begin
      wa.push_back(frame_addr);
      wd.push_back(frame_data);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c,
                                          input logic b);
    logic f;
    f = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
  endfunction

  task automatic send_bit(input logic b, input bit stall);
    if (stall && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
      end
    end
    @(negedge clk);
    en        = 1'b1;
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk);
  endtask

  task automatic send_field(input logic [31:0] v, input int nb,
                            input bit stall, input bit to_crc);
    for (int i = nb - 1; i >= 0; i--) begin
      send_bit(v[i], stall);
      if (to_crc) crc_m = crc_step(crc_m, v[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      en        = 1'b1;
    end
  endtask

  task automatic send_sync();
    send_field(SYNC, 32, 1'b0, 1'b0);
    crc_m = 8'h00;
  endtask

  task automatic send_trailer(input bit flip);
`ifdef CFG_LOADER_CRC_EN
    send_field({24'h0, crc_m ^ {7'h0, flip}}, 8, 1'b0, 1'b0);
`else
    if (flip) crc_m = crc_m;
`endif
  endtask

  task automatic send_load(input logic [7:0] n, input int nfr,
                           input bit stall, input bit flip);
    wa.delete();
    wd.delete();
    send_sync();
    send_field({24'h0, n}, 8, stall, 1'b1);
    for (int f = 0; f < nfr; f++) begin
      if (stall && f == 0) begin
        send_field(fr[0] >> 22, 10, 1'b1, 1'b1);
        repeat (5) begin
          @(negedge clk);
          en        = 1'b0;
          bit_valid = 1'b1;
          bit_in    = 1'($urandom);
        end
        send_field(fr[0], 22, 1'b1, 1'b1);
      end else begin
        send_field(fr[f], 32, stall, 1'b1);
      end
    end
    if (nfr > 0) send_trailer(flip);
    idle(3);
  endtask

  task automatic check_load(input string nm, input int nwe,
                            input logic d, input logic e);
    chk({nm, "_nwe"}, 64'(wa.size()), 64'(nwe));
    chk({nm, "_done"}, 64'(done), 64'(d));
    chk({nm, "_err"}, 64'(err), 64'(e));
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    for (int i = 0; i < nwe && i < wa.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 64'(wa[i]), 64'(i));
      chk($sformatf("%s_data%0d", nm, i), 64'(wd[i]), 64'(fr[i]));
    end
  endtask

  typedef struct {
    logic [7:0]  n;
    int          nfr;
    logic [31:0] seed;
    logic        d;
    logic        e;
    int          nwe;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'd1,   1, 32'hA5A5_0001, 1'b1, 1'b0, 1};
    vecs[1] = '{8'd0,   0, 32'h0,         1'b0, 1'b1, 0};
    vecs[2] = '{8'd9,   0, 32'h0,         1'b0, 1'b1, 0};
    vecs[3] = '{8'd8,   8, 32'h0F1E_2D3C, 1'b1, 1'b0, 8};
    vecs[4] = '{8'd3,   3, 32'hFFFF_0000, 1'b1, 1'b0, 3};
    vecs[5] = '{8'd255, 0, 32'h0,         1'b0, 1'b1, 0};

    rst = 1'b1; en = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    crc_m = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 64'(frame_data), 64'd0);
    chk("rst_addr", 64'(frame_addr), 64'd0);
    chk("rst_we",   64'(frame_we),   64'd0);
    chk("rst_busy", 64'(busy),       64'd0);
    chk("rst_done", 64'(done),       64'd0);
    chk("rst_err",  64'(err),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // nominal load with cycle-exact strobe checks
    fr[0] = 32'hDEAD_BEEF;
    fr[1] = 32'h1234_5678;
    wa.delete();
    wd.delete();
    send_sync();
    #1 chk("nom_busy_hdr", 64'(busy), 64'd1);
    send_field(32'd2, 8, 1'b0, 1'b1);
    send_field(fr[0], 32, 1'b0, 1'b1);
    #1;
    chk("nom_we0",   64'(frame_we),   64'd1);
    chk("nom_addr0", 64'(frame_addr), 64'd0);
    chk("nom_data0", 64'(frame_data), 64'(fr[0]));
    chk("nom_done0", 64'(done),       64'd0);
    send_field(fr[1], 32, 1'b0, 1'b1);
    #1;
    chk("nom_we1",   64'(frame_we),   64'd1);
    chk("nom_addr1", 64'(frame_addr), 64'd1);
    chk("nom_data1", 64'(frame_data), 64'(fr[1]));
`ifndef CFG_LOADER_CRC_EN
    chk("nom_done1", 64'(done), 64'd1);
    chk("nom_busy1", 64'(busy), 64'd0);
`endif
    @(negedge clk);
    en        = 1'b0;
    bit_valid = 1'b0;
    @(posedge clk);
    #1 chk("nom_we_clr_en0", 64'(frame_we), 64'd0);
    send_trailer(1'b0);
    idle(3);
    check_load("nom", 2, 1'b1, 1'b0);

    // same stream with bit_valid gaps and en low inside frame 0
    send_load(8'd2, 2, 1'b1, 1'b0);
    check_load("stall", 2, 1'b1, 1'b0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++)
        fr[i] = vecs[v].seed + 32'(i) * 32'h1111_1111;
      send_load(vecs[v].n, vecs[v].nfr, 1'b0, 1'b0);
      check_load($sformatf("vec%0d", v), vecs[v].nwe,
                 vecs[v].d, vecs[v].e);
    end

    // reset 10 bits into frame 1
    fr[0] = 32'hCAFE_F00D;
    fr[1] = 32'hBADC_0FFE;
    wa.delete();
    wd.delete();
    send_sync();
    send_field(32'd2, 8, 1'b0, 1'b1);
    send_field(fr[0], 32, 1'b0, 1'b1);
    send_field(fr[1] >> 22, 10, 1'b0, 1'b1);
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_data", 64'(frame_data), 64'd0);
    chk("mrst_addr", 64'(frame_addr), 64'd0);
    chk("mrst_we",   64'(frame_we),   64'd0);
    chk("mrst_busy", 64'(busy),       64'd0);
    chk("mrst_done", 64'(done),       64'd0);
    chk("mrst_err",  64'(err),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    send_field(fr[1], 22, 1'b0, 1'b0);
    idle(3);
    chk("mrst_nwe", 64'(wa.size()), 64'd1);
    send_load(8'd2, 2, 1'b0, 1'b0);
    check_load("mrst_reload", 2, 1'b1, 1'b0);

    // sync hunt: garbage, partial sync, full sync, sync word as data
    fr[0] = SYNC;
    wa.delete();
    wd.delete();
    send_field(32'b101, 3, 1'b0, 1'b0);
    send_field(32'hFAB0, 16, 1'b0, 1'b0);
    #1 chk("hunt_nolock", 64'(busy), 64'd0);
    send_sync();
    #1 chk("hunt_lock", 64'(busy), 64'd1);
    send_field(32'd1, 8, 1'b0, 1'b1);
    send_field(fr[0], 32, 1'b0, 1'b1);
    send_trailer(1'b0);
    idle(3);
    check_load("hunt", 1, 1'b1, 1'b0);

`ifdef CFG_LOADER_CRC_EN
    fr[0] = 32'h0BAD_CAFE;
    fr[1] = 32'h7777_AAAA;
    send_load(8'd2, 2, 1'b0, 1'b1);
    check_load("crc_bad", 2, 1'b0, 1'b1);
    send_load(8'd2, 2, 1'b0, 1'b0);
    check_load("crc_good", 2, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
